// File: rtl/can_pkg.sv
// Shared CAN receive-path types, defaults and helpers.
// Used by the destuffer, the CRC block and the stuff-count checker.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DYNAMIC = 2'd1,
    FIXED   = 2'd2
  } state_e;

  localparam int unsigned STUFF_WIDTH_DEF  = 5;
  localparam int unsigned FIXED_PERIOD_DEF = 4;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/stuff_counter.sv
// Counts dynamic stuff bits mod 8.
// Presents the count Gray coded, with even parity.
module stuff_counter
  import can_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] stuffCount,
  output logic       stuffParity
);

  logic [2:0] cnt_q, cnt_d;

  // next count: clear on frame start, else bump per stuff bit
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = 3'd0;
    else if (inc)
      cnt_d = cnt_q + 3'd1;
  end

  // binary count register
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 3'd0;
    else
      cnt_q <= cnt_d;
  end

  assign stuffCount  = bin2gray(cnt_q);
  assign stuffParity = ^stuffCount;

endmodule

// File: rtl/bit_destuffer.sv
// Classifies sampled CAN bits as data or stuff, checks stuffing.
// Optional stuff counter under BIT_DESTUFFER_STUFF_COUNT_EN.
module bit_destuffer
  import can_pkg::*;
#(
  parameter int unsigned STUFF_WIDTH  = STUFF_WIDTH_DEF,
  parameter int unsigned FIXED_PERIOD = FIXED_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       samplePoint,
  input  logic       canRX,
  input  logic       destuff_on,
  input  logic       fixedStuff_on,
  output logic       dataBit,
  output logic       dataValid,
  output logic       isStuff,
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
  output logic [2:0] stuffCount,
  output logic       stuffParity,
`endif
  output logic       stuffError
);

  localparam logic [2:0] SW = 3'(STUFF_WIDTH);
  localparam logic [2:0] FP = 3'(FIXED_PERIOD);

  state_e     state_q, state_d;
  logic [2:0] run_q, run_d;
  logic [2:0] fix_q, fix_d;
  logic       prev_q, prev_d;
  logic       bit_q, bit_d;
  logic       dv_q, dv_d;
  logic       st_q, st_d;
  logic       err_q, err_d;
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
  logic       cnt_clr;
  logic       cnt_inc;
`endif

  // next-state and classification of the current sample
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    fix_d   = fix_q;
    prev_d  = prev_q;
    bit_d   = bit_q;
    dv_d    = 1'b0;
    st_d    = 1'b0;
    err_d   = 1'b0;
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`endif
    if (!destuff_on) begin
      state_d = IDLE;
      run_d   = 3'd0;
      fix_d   = 3'd0;
    end else if (samplePoint) begin
      bit_d  = canRX;
      prev_d = canRX;
      unique case (state_q)
        IDLE: begin
          state_d = DYNAMIC;
          dv_d    = 1'b1;
          run_d   = 3'd1;
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
          cnt_clr = 1'b1;
`endif
        end
        DYNAMIC: begin
          if (fixedStuff_on) begin
            state_d = FIXED;
            st_d    = 1'b1;
            err_d   = (canRX == prev_q);
            fix_d   = 3'd0;
            run_d   = 3'd1;
          end else if (run_q >= SW) begin
            st_d    = 1'b1;
            err_d   = (canRX == prev_q);
            run_d   = 3'd1;
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
            cnt_inc = 1'b1;
`endif
          end else begin
            dv_d = 1'b1;
            if (canRX != prev_q)
              run_d = 3'd1;
            else if (run_q < SW)
              run_d = run_q + 3'd1;
          end
        end
        FIXED: begin
          if (fix_q >= FP) begin
            st_d  = 1'b1;
            err_d = (canRX == prev_q);
            fix_d = 3'd0;
          end else begin
            dv_d  = 1'b1;
            fix_d = fix_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          bit_d   = bit_q;
          prev_d  = prev_q;
        end
      endcase
    end
  end

  // state, history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= 3'd0;
      fix_q   <= 3'd0;
      prev_q  <= 1'b1;
      bit_q   <= 1'b0;
      dv_q    <= 1'b0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      fix_q   <= fix_d;
      prev_q  <= prev_d;
      bit_q   <= bit_d;
      dv_q    <= dv_d;
      st_q    <= st_d;
      err_q   <= err_d;
    end
  end

  assign dataBit    = bit_q;
  assign dataValid  = dv_q;
  assign isStuff    = st_q;
  assign stuffError = err_q;

`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
  stuff_counter u_cnt (
    .clk         (clk),
    .reset       (reset),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .stuffCount  (stuffCount),
    .stuffParity (stuffParity)
  );
`endif

endmodule

// File: tb/tb_bit_destuffer.sv
// Randomized and directed bench for bit_destuffer.
// Reference model works on the per-frame bit history.
module tb_bit_destuffer;

  localparam int SWID = 5;
  localparam int FPER = 4;

  logic clk = 1'b0;
  logic reset, samplePoint, canRX, destuff_on, fixedStuff_on;
  logic dataBit, dataValid, isStuff, stuffError;
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
  logic [2:0] stuffCount;
  logic       stuffParity;
`endif

  always #5 clk = ~clk;

  bit_destuffer #(.STUFF_WIDTH(SWID), .FIXED_PERIOD(FPER)) dut (
    .clk           (clk),
    .reset         (reset),
    .samplePoint   (samplePoint),
    .canRX         (canRX),
    .destuff_on    (destuff_on),
    .fixedStuff_on (fixedStuff_on),
    .dataBit       (dataBit),
    .dataValid     (dataValid),
    .isStuff       (isStuff),
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
    .stuffCount    (stuffCount),
    .stuffParity   (stuffParity),
`endif
    .stuffError    (stuffError)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: bit history of the current frame and its kinds
  // kind 0 = data, 1 = dynamic stuff, 2 = fixed stuff
  bit   m_act, m_fix;
  logic m_hb[$];
  int   m_hk[$];
  int   m_sc;
  logic e_dv, e_st, e_err, e_db;
  int   tot_dv, tot_st, tot_err;

  task automatic mdl_clear();
    m_act = 0;
    m_fix = 0;
    m_hb.delete();
    m_hk.delete();
  endtask

  task automatic mdl(input logic sp, input logic rx, input logic don,
                     input logic fon, input logic rst);
    int   cnt;
    logic last;
    e_dv = 0;
    e_st = 0;
    e_err = 0;
    if (rst) begin
      mdl_clear();
      e_db = 0;
      m_sc = 0;
    end else if (!don) begin
      mdl_clear();
    end else if (sp) begin
      e_db = rx;
      if (!m_act) begin
        m_act = 1;
        m_sc = 0;
        e_dv = 1;
        m_hb.push_back(rx);
        m_hk.push_back(0);
      end else begin
        last = m_hb[m_hb.size()-1];
        if (!m_fix && fon) begin
          m_fix = 1;
          e_st = 1;
          e_err = (rx == last);
          m_hb.push_back(rx);
          m_hk.push_back(2);
        end else if (!m_fix) begin
          cnt = 0;
          for (int k = m_hb.size()-1; k >= 0; k--) begin
            if (m_hb[k] != last) break;
            cnt++;
            if (m_hk[k] != 0) break;
          end
          if (cnt >= SWID) begin
            e_st = 1;
            e_err = (rx == last);
            m_sc = (m_sc + 1) % 8;
            m_hk.push_back(1);
          end else begin
            e_dv = 1;
            m_hk.push_back(0);
          end
          m_hb.push_back(rx);
        end else begin
          cnt = 0;
          for (int k = m_hk.size()-1; k >= 0; k--) begin
            if (m_hk[k] == 2) break;
            cnt++;
          end
          if (cnt >= FPER) begin
            e_st = 1;
            e_err = (rx == last);
            m_hk.push_back(2);
          end else begin
            e_dv = 1;
            m_hk.push_back(0);
          end
          m_hb.push_back(rx);
        end
      end
    end
  endtask

  task automatic step(input logic sp, input logic rx, input logic don,
                      input logic fon, input logic rst);
    logic [2:0] g;
    samplePoint = sp;
    canRX = rx;
    destuff_on = don;
    fixedStuff_on = fon;
    reset = rst;
    @(posedge clk);
    #1;
    mdl(sp, rx, don, fon, rst);
    tot_dv += int'(dataValid);
    tot_st += int'(isStuff);
    tot_err += int'(stuffError);
    chk("dataValid", 32'(dataValid), 32'(e_dv));
    chk("isStuff", 32'(isStuff), 32'(e_st));
    chk("stuffError", 32'(stuffError), 32'(e_err));
    chk("dataBit", 32'(dataBit), 32'(e_db));
    g = 3'(m_sc ^ (m_sc >> 1));
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
    chk("stuffCount", 32'(stuffCount), 32'(g));
    chk("stuffParity", 32'(stuffParity), 32'(^g));
`endif
  endtask

  task automatic tally_clr();
    tot_dv = 0;
    tot_st = 0;
    tot_err = 0;
  endtask

  task automatic gap();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask

  logic v;
  logic rxr;
  logic fon_r;
  int   len, fst;

  initial begin
    mdl_clear();
    m_sc = 0;
    e_db = 0;
    tally_clr();
    step(1, 1, 1, 1, 1);
    step(0, 1, 0, 0, 1);
    chk("rst_dv", 32'(dataValid), 0);

    // five zeros, stuff 1, data 1
    tally_clr();
    step(1, 0, 1, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t1_stuff_now", 32'(isStuff), 1);
    step(1, 1, 1, 0, 0);
    chk("t1_dv", 32'(tot_dv), 6);
    chk("t1_st", 32'(tot_st), 1);
    gap();

    // stuff bit with same level, then a fresh run
    tally_clr();
    repeat (5) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t2_err_now", 32'(stuffError), 1);
    repeat (4) step(1, 1, 1, 0, 0);
    chk("t2_err", 32'(tot_err), 1);
    chk("t2_st", 32'(tot_st), 1);
    gap();

    // alternating bits
    tally_clr();
    for (int i = 0; i < 20; i++) step(1, 1'(i % 2), 1, 0, 0);
    chk("t3_dv", 32'(tot_dv), 20);
    chk("t3_st", 32'(tot_st), 0);
    gap();

    // fixed stuffing
    tally_clr();
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t4_err_now", 32'(stuffError), 1);
    chk("t4_st", 32'(tot_st), 2);
    chk("t4_err", 32'(tot_err), 1);
    repeat (6) step(1, 0, 1, 0, 0);
    gap();

    // reset mid-run, then idle samples ignored
    step(1, 0, 1, 0, 0);
    repeat (3) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    chk("t5_dv", 32'(dataValid), 0);
    chk("t5_db", 32'(dataBit), 0);
    tally_clr();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t5_idle", 32'(tot_dv + tot_st), 0);

    // eleven dynamic stuff bits
    tally_clr();
    v = 0;
    step(1, v, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      repeat (4) step(1, v, 1, 0, 0);
      v = ~v;
      step(1, v, 1, 0, 0);
    end
    chk("t6_st", 32'(tot_st), 11);
`ifdef BIT_DESTUFFER_STUFF_COUNT_EN
    chk("t6_gray", 32'(stuffCount), 32'(3'b010));
    chk("t6_par", 32'(stuffParity), 1);
    step(1, v, 1, 1, 0);
    repeat (12) step(1, v, 1, 0, 0);
    chk("t6_frozen", 32'(stuffCount), 32'(3'b010));
`endif
    gap();

    // random frames
    for (int f = 0; f < 40; f++) begin
      len = 20 + int'($urandom_range(0, 60));
      fst = ($urandom_range(0, 2) == 0) ? len + 1
            : int'($urandom_range(2, 50));
      rxr = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) rxr = ~rxr;
        fon_r = (c >= fst) && (c < fst + 25);
        step(1'($urandom_range(0, 4) != 0), rxr, 1, fon_r,
             1'($urandom_range(0, 199) == 0));
      end
      repeat (1 + int'($urandom_range(0, 2)))
        step(1'($urandom_range(0, 1)), 1, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
